// File: rtl/state_transfer_engine_if.sv
// rtl/state_transfer_engine_if.sv - data-RAM port between the state transfer engine and a single-port RAM
// The engine drives the master side. Read data returns one cycle after the address.
interface state_transfer_engine_if #(
  parameter int addrBits = 8,
  parameter int dataBits = 16
);
  logic [addrBits-1:0] ramAddress;
  logic                ramReadWriteMode;
  logic [dataBits-1:0] ramDataIn;
  logic [dataBits-1:0] ramDataOut;

  modport master (
    output ramAddress,
    output ramReadWriteMode,
    output ramDataIn,
    input  ramDataOut
  );

  modport slave (
    input  ramAddress,
    input  ramReadWriteMode,
    input  ramDataIn,
    output ramDataOut
  );
endinterface

// File: rtl/state_transfer_engine.sv
// rtl/state_transfer_engine.sv - saves/restores a numWords process context to/from a single-port RAM
// Optional trailing XOR checksum word: define STATE_TRANSFER_CHECKSUM_EN.
module state_transfer_engine #(
  parameter int addrBits = 8,
  parameter int dataBits = 16,
  parameter int numWords = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   command,
  input  logic [addrBits-1:0]          baseAddress,
  input  logic [numWords*dataBits-1:0] contextIn,
  output logic [numWords*dataBits-1:0] contextOut,
  output logic                         busy,
  output logic                         done,
  output logic                         checksumError,
  state_transfer_engine_if.master      ram
);
  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;
  localparam logic [1:0] CMD_SAVE    = 2'd1;
  localparam logic [1:0] CMD_RESTORE = 2'd2;

`ifdef STATE_TRANSFER_CHECKSUM_EN
  localparam int T = numWords + 1;
`else
  localparam int T = numWords;
`endif
  localparam int idxBits = $clog2(T + 1);
  localparam logic [idxBits-1:0] LAST  = idxBits'(T - 1);
  localparam logic [idxBits-1:0] FINAL = idxBits'(T);

  typedef enum logic [1:0] {IDLE, SAVE, LOAD, DONE} stateType;

  stateType            state;
  logic [idxBits-1:0]  idx;
  logic [idxBits-1:0]  capIdx;
  logic                capEn;
  logic                wasRestore;
  logic [addrBits-1:0] snapBase;
  logic [dataBits-1:0] snapWords [numWords];
  logic [dataBits-1:0] shadow [T];
  logic [dataBits-1:0] saveWord;

`ifdef STATE_TRANSFER_CHECKSUM_EN
  logic [dataBits-1:0] snapXor;
  logic [dataBits-1:0] shadowXor;

  always_comb begin
    snapXor   = '0;
    shadowXor = '0;
    for (int k = 0; k < numWords; k++) begin
      snapXor   = snapXor ^ snapWords[k];
      shadowXor = shadowXor ^ shadow[k];
    end
  end
`endif

  always_comb begin
    saveWord = '0;
    for (int k = 0; k < numWords; k++)
      if (idx == idxBits'(k)) saveWord = snapWords[k];
`ifdef STATE_TRANSFER_CHECKSUM_EN
    if (idx == idxBits'(numWords)) saveWord = snapXor;
`endif
  end

  // The state register runs one cycle ahead of the registered bus outputs:
  // the state entered at the command edge drives the RAM from the next edge on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      idx                  <= '0;
      capIdx               <= '0;
      capEn                <= 1'b0;
      wasRestore           <= 1'b0;
      snapBase             <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      checksumError        <= 1'b0;
      contextOut           <= '0;
      ram.ramAddress       <= '0;
      ram.ramReadWriteMode <= RAM_READ;
      ram.ramDataIn        <= '0;
    end else begin
      done                 <= 1'b0;
      checksumError        <= 1'b0;
      capEn                <= 1'b0;
      ram.ramReadWriteMode <= RAM_READ;
      ram.ramDataIn        <= '0;

      for (int k = 0; k < T; k++)
        if (capEn && capIdx == idxBits'(k)) shadow[k] <= ram.ramDataOut;

      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          // done still high here marks the closing edge of the DONE cycle
          if (done && wasRestore)
            for (int k = 0; k < numWords; k++)
              contextOut[k*dataBits +: dataBits] <= shadow[k];
          if (!done && (command == CMD_SAVE || command == CMD_RESTORE)) begin
            snapBase   <= baseAddress;
            for (int k = 0; k < numWords; k++)
              snapWords[k] <= contextIn[k*dataBits +: dataBits];
            wasRestore <= (command == CMD_RESTORE);
            idx        <= '0;
            state      <= (command == CMD_SAVE) ? SAVE : LOAD;
          end
        end

        SAVE: begin
          busy                 <= 1'b1;
          ram.ramAddress       <= snapBase + addrBits'(idx);
          ram.ramReadWriteMode <= RAM_WRITE;
          ram.ramDataIn        <= saveWord;
          if (idx == LAST) state <= DONE;
          else             idx   <= idx + 1'b1;
        end

        LOAD: begin
          busy <= 1'b1;
          if (idx != FINAL) ram.ramAddress <= snapBase + addrBits'(idx);
          // word idx-1 is on ramDataOut during this output cycle
          if (idx != '0) begin
            capEn  <= 1'b1;
            capIdx <= idx - 1'b1;
          end
          if (idx == FINAL) state <= DONE;
          else              idx   <= idx + 1'b1;
        end

        DONE: begin
          busy  <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
`ifdef STATE_TRANSFER_CHECKSUM_EN
          // checksum word is still on ramDataOut; data words are already in shadow
          checksumError <= wasRestore && (shadowXor != ram.ramDataOut);
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_state_transfer_engine.sv
// tb/tb_state_transfer_engine.sv - scoreboard bench for state_transfer_engine with a RAM and context model
// Honours STATE_TRANSFER_CHECKSUM_EN when it is defined for the build.
module tb_state_transfer_engine;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NW = 5;
`ifdef STATE_TRANSFER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int T = CSUM ? NW + 1 : NW;

  typedef logic [NW*DB-1:0] ctx_t;
  typedef struct { int cyc; logic [AB-1:0] addr; logic [DB-1:0] data; } wr_t;
  typedef struct { int cyc; bit restore; bit err; ctx_t ctx; } dn_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    command = 2'd0;
  logic [AB-1:0] baseAddress = '0;
  ctx_t          contextIn = '0;
  ctx_t          contextOut;
  logic          busy, done, checksumError;

  state_transfer_engine_if #(.addrBits(AB), .dataBits(DB)) ramBus ();

  state_transfer_engine #(.addrBits(AB), .dataBits(DB), .numWords(NW)) dut (
    .clk(clk), .reset(reset), .command(command), .baseAddress(baseAddress),
    .contextIn(contextIn), .contextOut(contextOut), .busy(busy), .done(done),
    .checksumError(checksumError), .ram(ramBus.master)
  );

  always #5 clk = ~clk;

  logic [DB-1:0] mem [256] = '{default: '0};
  logic          bdEn = 1'b0;
  logic [AB-1:0] bdAddr = '0;
  logic [DB-1:0] bdData = '0;

  always @(posedge clk) begin
    if (bdEn) mem[bdAddr] <= bdData;
    else if (ramBus.ramReadWriteMode) mem[ramBus.ramAddress] <= ramBus.ramDataIn;
    ramBus.ramDataOut <= mem[ramBus.ramAddress];
  end

  logic [DB-1:0] refMem [256];
  wr_t  wrQ[$];
  dn_t  dnQ[$];
  wr_t  mw;
  dn_t  md;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   busyFrom = -1;
  int   busyTo = -1;
  ctx_t expCtx = '0;
  bit   armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chkW(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    chkW(name, 128'(act), 128'(exp));
  endfunction

  function automatic void miss(string name, string detail);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endfunction

  function automatic logic [DB-1:0] word(ctx_t c, int k);
    return c[k*DB +: DB];
  endfunction

  // Monitor: checks every DUT output cycle against the scoreboard queues
  always @(negedge clk) begin
    if (armed) begin
      chk1("busy", busy, cyc >= busyFrom && cyc <= busyTo);
      chkW("contextOut", 128'(contextOut), 128'(expCtx));
      if (ramBus.ramReadWriteMode === 1'b1) begin
        if (wrQ.size() == 0) miss("write", $sformatf("unexpected write to %0h", ramBus.ramAddress));
        else begin
          mw = wrQ.pop_front();
          chkW("write cycle", 128'(cyc), 128'(mw.cyc));
          chkW("write addr", 128'(ramBus.ramAddress), 128'(mw.addr));
          chkW("write data", 128'(ramBus.ramDataIn), 128'(mw.data));
        end
      end else begin
        chkW("ramDataIn outside write", 128'(ramBus.ramDataIn), 128'(0));
        if (wrQ.size() != 0 && wrQ[0].cyc <= cyc) begin
          mw = wrQ.pop_front();
          miss("write", $sformatf("expected write to %0h missing", mw.addr));
        end
      end
      if (done === 1'b1) begin
        if (dnQ.size() == 0) miss("done", "unexpected done pulse");
        else begin
          md = dnQ.pop_front();
          chkW("done cycle", 128'(cyc), 128'(md.cyc));
          chk1("checksumError", checksumError, md.err);
          if (md.restore) expCtx = md.ctx;
        end
      end else begin
        chk1("checksumError outside done", checksumError, 1'b0);
        if (dnQ.size() != 0 && dnQ[0].cyc <= cyc) begin
          md = dnQ.pop_front();
          miss("done", "expected done pulse missing");
        end
      end
    end
  end

  task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
    bdEn = 1'b1; bdAddr = a; bdData = d;
    @(posedge clk); #1;
    bdEn = 1'b0;
    refMem[a] = d;
  endtask

  // Issues one command, pushes the model's expectations, then waits until the
  // first cycle in which the engine may accept the next command.
  task automatic issue(input bit restore, input logic [AB-1:0] base, input ctx_t ctx, input bit noise);
    int            e0;
    int            n;
    logic [AB-1:0] a;
    logic [DB-1:0] x;
    logic [DB-1:0] d;
    ctx_t          got;
    bit            err;
    command = restore ? 2'd2 : 2'd1;
    baseAddress = base;
    contextIn = ctx;
    @(posedge clk); #1;
    e0 = cyc;
    command = noise ? (restore ? 2'd1 : 2'd2) : 2'd0;
    if (noise) begin
      contextIn = ctx_t'({$urandom(), $urandom(), $urandom()});
      baseAddress = AB'($urandom());
    end
    x = '0;
    busyFrom = e0 + 1;
    if (!restore) begin
      for (int k = 0; k < NW; k++) x = x ^ word(ctx, k);
      for (int k = 0; k < T; k++) begin
        a = base + AB'(k);
        d = (k < NW) ? word(ctx, k) : x;
        refMem[a] = d;
        wrQ.push_back('{cyc: e0 + 1 + k, addr: a, data: d});
      end
      dnQ.push_back('{cyc: e0 + T + 1, restore: 1'b0, err: 1'b0, ctx: '0});
      busyTo = e0 + T + 1;
      n = T + 2;
    end else begin
      got = '0;
      for (int k = 0; k < NW; k++) begin
        got[k*DB +: DB] = refMem[base + AB'(k)];
        x = x ^ refMem[base + AB'(k)];
      end
      err = CSUM && (x != refMem[base + AB'(NW)]);
      dnQ.push_back('{cyc: e0 + T + 2, restore: 1'b1, err: err, ctx: got});
      busyTo = e0 + T + 2;
      n = T + 3;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == T - 1) command = 2'd0;
    end
    chkW("writes outstanding", 128'(wrQ.size()), 128'(0));
    chkW("done outstanding", 128'(dnQ.size()), 128'(0));
  endtask

  initial begin
    ctx_t          c;
    int            e0;
    logic [AB-1:0] a;
    logic [AB-1:0] b;
    for (int i = 0; i < 256; i++) refMem[i] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset checksumError", checksumError, 1'b0);
    chkW("reset contextOut", 128'(contextOut), 128'(0));
    chkW("reset ramAddress", 128'(ramBus.ramAddress), 128'(0));
    chk1("reset mode", ramBus.ramReadWriteMode, 1'b0);
    reset = 1'b0;
    armed = 1'b1;

    command = 2'd3;
    repeat (4) @(posedge clk);
    #1;
    command = 2'd0;
    repeat (2) @(posedge clk);
    #1;

    c = {16'd42, 16'd7, 16'd4, 16'h00FD, 16'd1};
    issue(1'b0, 8'h20, c, 1'b0);
    issue(1'b1, 8'h20, '0, 1'b0);
    chkW("restored context 0x20", 128'(expCtx), 128'(c));

    c = ctx_t'({$urandom(), $urandom(), $urandom()});
    issue(1'b0, 8'hFE, c, 1'b0);
    issue(1'b1, 8'hFE, '0, 1'b0);

    c = ctx_t'({$urandom(), $urandom(), $urandom()});
    issue(1'b0, 8'h30, c, 1'b1);
    issue(1'b1, 8'h30, '0, 1'b1);

    // reset lands on the edge that would start the third write
    c = ctx_t'({$urandom(), $urandom(), $urandom()});
    b = 8'h40;
    command = 2'd1; baseAddress = b; contextIn = c;
    @(posedge clk); #1;
    e0 = cyc;
    command = 2'd0;
    for (int k = 0; k < 2; k++) begin
      a = b + AB'(k);
      refMem[a] = word(c, k);
      wrQ.push_back('{cyc: e0 + 1 + k, addr: a, data: word(c, k)});
    end
    busyFrom = e0 + 1;
    busyTo = e0 + 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    expCtx = '0;
    chk1("mid-reset busy", busy, 1'b0);
    chk1("mid-reset done", done, 1'b0);
    chkW("mid-reset contextOut", 128'(contextOut), 128'(0));
    chkW("mid-reset ramAddress", 128'(ramBus.ramAddress), 128'(0));
    chk1("mid-reset mode", ramBus.ramReadWriteMode, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < T; k++)
      chkW("RAM after reset", 128'(mem[b + AB'(k)]), 128'(refMem[b + AB'(k)]));
    issue(1'b1, b, '0, 1'b0);

    c = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    issue(1'b0, 8'h60, c, 1'b0);
    chkW("checksum word in RAM", 128'(mem[8'h65]), 128'(CSUM ? 16'h0001 : 16'h0000));
    poke(8'h62, 16'h0103);
    issue(1'b1, 8'h60, '0, 1'b0);
    issue(1'b0, 8'h60, c, 1'b0);
    issue(1'b1, 8'h60, '0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) poke(AB'($urandom()), DB'($urandom()));
      issue(1'($urandom_range(0, 1)), AB'($urandom()),
            ctx_t'({$urandom(), $urandom(), $urandom()}), $urandom_range(0, 3) == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chkW("final writes outstanding", 128'(wrQ.size()), 128'(0));
    chkW("final done outstanding", 128'(dnQ.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
